mem_read_responder: RTL and testbench



---
 rtl/mem_map_pkg.sv | 29 ++
 rtl/mem_region_decode.sv | 24 ++
 rtl/mem_read_responder.sv | 138 +++++++++++++
 tb/tb_mem_read_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// CPU read-side memory map: region bounds, region and FSM state encodings.
// Shared by the read responder and any write-side decoder.
package mem_map_pkg;

  localparam logic [31:0] DMEM_SIZE = 32'd64;
  localparam logic [31:0] VMEM_BASE = 32'd64;
  localparam logic [31:0] VMEM_END  = 32'd254063;
  localparam logic [31:0] CTRL_ADDR = 32'd254064;

  typedef enum logic [1:0] {
    REG_DMEM,
    REG_VMEM,
    REG_CTRL,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // WAIT lasts LAT cycles, so the down-counter starts at LAT-1.
  function automatic logic [1:0] lat_to_cnt(input int lat);
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational byte-address to region decode plus video-RAM rebased offset.
// Zero latency, no flow control.
module mem_region_decode
  import mem_map_pkg::*;
(
  input  logic [31:0] addr,
  output region_t     region,
  output logic [31:0] vmem_off
);

  always_comb begin
    region = REG_NONE;
    if (addr < DMEM_SIZE) begin
      region = REG_DMEM;
    end else if (addr <= VMEM_END) begin
      region = REG_VMEM;
    end else if (addr == CTRL_ADDR) begin
      region = REG_CTRL;
    end
  end

  assign vmem_off = addr - VMEM_BASE;

endmodule

// File: rtl/mem_read_responder.sv
// Single-outstanding CPU read responder over data RAM, video RAM and a control register.
// Response LAT+2 cycles after accept for RAMs, 1 for CTRL/unmapped; held while rsp_ready=0.
module mem_read_responder
  import mem_map_pkg::*;
#(
  parameter int DMEM_LAT = 1,
  parameter int VMEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        dmem_rd,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic        vmem_rd,
  output logic [31:0] vmem_addr,
  input  logic [31:0] vmem_rdata,
  input  logic [31:0] ctrl_status
);

  localparam logic [1:0] DMEM_CNT = lat_to_cnt(DMEM_LAT);
  localparam logic [1:0] VMEM_CNT = lat_to_cnt(VMEM_LAT);

  state_t      state_q, state_d;
  region_t     region_q, region_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] vmem_addr_q, vmem_addr_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  region_t     dec_region;
  logic [31:0] dec_vmem_off;
  logic        accept;

  mem_region_decode u_decode (
    .addr     (req_addr),
    .region   (dec_region),
    .vmem_off (dec_vmem_off)
  );

  assign accept = req_valid & req_ready;

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    cnt_d       = cnt_q;
    dmem_addr_d = dmem_addr_q;
    vmem_addr_d = vmem_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          region_d = dec_region;
          case (dec_region)
            REG_DMEM: begin
              dmem_addr_d = req_addr;
              rsp_err_d   = 1'b0;
              state_d     = ISSUE;
            end
            REG_VMEM: begin
              vmem_addr_d = dec_vmem_off;
              rsp_err_d   = 1'b0;
              state_d     = ISSUE;
            end
            REG_CTRL: begin
              rsp_data_d = ctrl_status;
              rsp_err_d  = 1'b0;
              state_d    = RESP;
            end
            default: begin
              rsp_data_d = 32'd0;
              rsp_err_d  = 1'b1;
              state_d    = RESP;
            end
          endcase
        end
      end
      ISSUE: begin
        cnt_d   = (region_q == REG_DMEM) ? DMEM_CNT : VMEM_CNT;
        state_d = WAIT;
      end
      WAIT: begin
        // Last WAIT cycle is ISSUE+LAT: the RAM data is valid on this edge.
        if (cnt_q == 2'd0) begin
          rsp_data_d = (region_q == REG_DMEM) ? dmem_rdata : vmem_rdata;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      region_q    <= REG_NONE;
      cnt_q       <= 2'd0;
      dmem_addr_q <= 32'd0;
      vmem_addr_q <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      cnt_q       <= cnt_d;
      dmem_addr_q <= dmem_addr_d;
      vmem_addr_q <= vmem_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE) & rst_n;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q & (state_q == RESP);
  assign dmem_rd   = (state_q == ISSUE) & (region_q == REG_DMEM);
  assign vmem_rd   = (state_q == ISSUE) & (region_q == REG_VMEM);
  assign dmem_addr = dmem_addr_q;
  assign vmem_addr = vmem_addr_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder with latency-accurate RAM models.
module tb_mem_read_responder;

  localparam int DLAT = 1;
  localparam int VLAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready = 1'b1;
  logic        dmem_rd;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic        vmem_rd;
  logic [31:0] vmem_addr;
  logic [31:0] vmem_rdata;
  logic [31:0] ctrl_status = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_read_responder #(.DMEM_LAT(DLAT), .VMEM_LAT(VLAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .dmem_rd    (dmem_rd),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .vmem_rd    (vmem_rd),
    .vmem_addr  (vmem_addr),
    .vmem_rdata (vmem_rdata),
    .ctrl_status(ctrl_status)
  );

  // RAM models: read data is valid only in the cycle LAT cycles after the strobe.
  logic [2:0] dpipe = 3'd0;
  logic [2:0] vpipe = 3'd0;
  always @(posedge clk) begin
    dpipe <= {dpipe[1:0], dmem_rd};
    vpipe <= {vpipe[1:0], vmem_rd};
  end
  assign dmem_rdata = dpipe[DLAT-1] ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
  assign vmem_rdata = vpipe[VLAT-1] ? (vmem_addr ^ 32'hA5A5_0000) : 32'h0BAD_1BAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input int exp_lat,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_d, input int exp_v, input int hold);
    int  n;
    int  dcnt;
    int  vcnt;
    logic seen;
    @(negedge clk);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_addr    = 32'hFFFF_FFF0;
    ctrl_status = ~ctrl_status;
    n = 0; dcnt = 0; vcnt = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (dmem_rd) dcnt++;
      if (vmem_rd) vcnt++;
      if (rsp_valid) seen = 1'b1;
    end
    chk({tag, "_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({tag, "_dmem_rd_cycles"}, 32'(dcnt), 32'(exp_d));
    chk({tag, "_vmem_rd_cycles"}, 32'(vcnt), 32'(exp_v));
    chk({tag, "_rsp_data"}, rsp_data, exp_data);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_hold_data"}, rsp_data, exp_data);
      chk({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      chk({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_after_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_after_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;

    // Reset with random inputs: every output stays at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid   = 1'($urandom);
      req_addr    = $urandom;
      rsp_ready   = 1'($urandom);
      ctrl_status = $urandom;
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rd_strobes", {30'd0, dmem_rd, vmem_rd}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_vmem_addr", vmem_addr, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("rst_release_req_ready", {31'd0, req_ready}, 32'd1);

    do_read("dmem_10", 32'h10, 2 + DLAT, 32'hDEAD_BEEF, 1'b0, 1, 0, 0);
    chk("dmem_10_addr", dmem_addr, 32'h10);

    do_read("vmem_lo", 32'd64, 2 + VLAT, 32'd0 ^ 32'hA5A5_0000, 1'b0, 0, 1, 0);
    chk("vmem_lo_addr", vmem_addr, 32'd0);
    chk("vmem_lo_dmem_addr_held", dmem_addr, 32'h10);

    do_read("vmem_hi", 32'd254063, 2 + VLAT, 32'd253999 ^ 32'hA5A5_0000, 1'b0, 0, 1, 0);
    chk("vmem_hi_addr", vmem_addr, 32'd253999);

    ctrl_status = 32'h5;
    do_read("ctrl", 32'd254064, 1, 32'h5, 1'b0, 0, 0, 0);

    do_read("unmapped_254065", 32'd254065, 1, 32'd0, 1'b1, 0, 0, 0);
    do_read("unmapped_top", 32'hFFFF_FFFF, 1, 32'd0, 1'b1, 0, 0, 0);
    chk("unmapped_vmem_addr_held", vmem_addr, 32'd253999);

    do_read("bp_dmem", 32'h4, 2 + DLAT, 32'hDEAD_BEEF, 1'b0, 1, 0, 5);
    do_read("bp_none", 32'd254070, 1, 32'd0, 1'b1, 0, 0, 5);

    // Reset pulse while the DMEM read is in WAIT: the read must vanish.
    @(negedge clk);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = 32'h20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_issue_strobe", {31'd0, dmem_rd}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready_low", {31'd0, req_ready}, 32'd0);
    chk("midrst_dmem_addr", dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || dmem_rd) seen = 1'b1;
    end
    chk("midrst_no_response", {31'd0, seen}, 32'd0);

    do_read("dmem_63", 32'd63, 2 + DLAT, 32'hDEAD_BEEF, 1'b0, 1, 0, 0);
    chk("dmem_63_addr", dmem_addr, 32'd63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
